axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
Single-outstanding AXI4-Lite initiator. It converts a simple request/response command port into AXI4-Lite read and write transactions. It drives the accelerator CSR slave from host-side bring-up logic, testbenches and the command sequencer. It also reports bus error responses and stalled transactions to the issuing logic.

Parameters:
ADDR_WIDTH, 8, AXI address width (matches CSR address space).
DATA_WIDTH, 32, AXI data width; must be a multiple of 8.
TIMEOUT_CYCLES, 1024, cycles a transaction may wait in an AXI phase before timeout_err sets; must be at least 2.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  command request valid.
req_ready  out  1  high in IDLE only.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  target address.
req_wdata  in  DATA_WIDTH  write data.
req_wstrb  in  DATA_WIDTH/8  write byte strobes.
req_prot  in  3  driven onto awprot/arprot.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accepted.
rsp_write  out  1  response belongs to a write.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
rsp_resp  out  2  captured BRESP/RRESP.
m_axi_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  write address channel; awready in 1.
m_axi_wdata/wstrb/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1  write data channel; wready in 1.
m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1  write response channel.
m_axi_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  read address channel; arready in 1.
m_axi_rdata in DATA_WIDTH, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1  read data channel.
busy  out  1  state != IDLE.
err_clr  in  1  clears the sticky error flags.
resp_err  out  1  sticky; set on any non-OKAY bresp or rresp.
timeout_err  out  1  sticky; set on timeout.

Behaviour:
- Reset (async, rst_n low): state = IDLE; every AXI valid/ready output, rsp_valid, rsp_write, busy, resp_err and timeout_err = 0; all address/data/resp registers = 0; req_ready = 1.
- All outputs are registered except req_ready and busy, which decode the state register.
- States: IDLE, WR_XFER, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: on req_valid && req_ready, capture addr/wdata/wstrb/prot/write.
  - Write: next state WR_XFER; awvalid and wvalid both rise in the following cycle (1-cycle issue latency).
  - Read: next state RD_ADDR; arvalid rises in the following cycle.
- WR_XFER: awvalid and wvalid drop independently on their own handshake (valid && ready). Either order is legal, as is the same cycle. Payloads stay stable while valid. Once both handshakes have completed, the next state is WR_RESP with bready = 1.
- WR_RESP: on bvalid && bready, capture bresp, drop bready, set rsp_write = 1, rsp_rdata = 0, next state RESP.
- RD_ADDR: on arvalid && arready, drop arvalid, raise rready, next state RD_DATA.
- RD_DATA: on rvalid && rready, capture rdata/rresp, drop rready, set rsp_write = 0, next state RESP.
- RESP: rsp_valid = 1 and payload held until rsp_ready; then rsp_valid = 0 and next state IDLE. A new request is accepted one cycle later at the earliest, giving single outstanding only.
- Valids never deassert before their handshake. Ready outputs are never asserted outside their phase state.
- resp_err sets in the capture cycle when the captured resp != 2'b00.
- Timeout: a counter clears on entry to WR_XFER or RD_ADDR and increments each cycle in WR_XFER, WR_RESP, RD_ADDR and RD_DATA. When it reaches TIMEOUT_CYCLES-1, timeout_err sets and the counter saturates. The transaction is NOT aborted and stays in protocol.
- err_clr clears both sticky flags. If err_clr coincides with a set event, set wins.
- Input changes on req_* while not in IDLE have no effect.
- Reset mid-transaction drops all valids immediately (asynchronously). No replay.

Decomposition:
- Package axi_lite_pkg holds:
  - Response codes RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - Master state enum.
  - The CSR DMA address constants 0x50–0x54, shared with the CSR slave.
- No sub-module. The timeout counter is inline.

Test Plan:
- Write 0x50 data 0xDEADBEEF, strb 0xF, prot 3'b001, awready/wready both 1 → AW and W handshakes land in the same cycle. One bready handshake follows. Response reports rsp_write = 1, rsp_resp = 00, and resp_err stays 0.
- Write with awready delayed 3 cycles while wready = 1 → wvalid drops after 1 cycle. awvalid holds exactly 4 cycles with stable awaddr. Exactly one B handshake follows.
- Read 0x53, slave returns rdata 0x0000_00A5 with rresp 00 after arready delay 2 and rvalid delay 1 → rsp_rdata = 0xA5, rsp_write = 0, one response.
- Read 0x7F, slave returns rresp 11 → rsp_resp = 11 and resp_err = 1 sticky. Pulsing err_clr clears it.
- TIMEOUT_CYCLES = 16, bvalid withheld 40 cycles → timeout_err = 1 at the 16th cycle in phase. bready stays 1, and the late B completes the response normally.
- Hold rsp_ready = 0 for 5 cycles with req_valid = 1 → req_ready stays 0 and rsp_valid/payload stay stable. A reset pulse during WR_XFER returns all outputs to reset values within the same cycle.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes, master FSM states
// and the CSR DMA register map used by master and CSR slave.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_XFER,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RESP
    } state_e;

    localparam logic [7:0] CSR_DMA_SRC  = 8'h50;
    localparam logic [7:0] CSR_DMA_DST  = 8'h51;
    localparam logic [7:0] CSR_DMA_LEN  = 8'h52;
    localparam logic [7:0] CSR_DMA_CTRL = 8'h53;
    localparam logic [7:0] CSR_DMA_STAT = 8'h54;

endpackage

// File: rtl/axi_lite_master_if.sv
// Command port and AXI4-Lite bus bundles for the single-outstanding
// initiator; master drives requests/addresses, slave answers.
interface axi_lite_cmd_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic [2:0]              req_prot;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_write;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic [1:0]              rsp_resp;

    modport master (
        output req_valid, req_write, req_addr,
        output req_wdata, req_wstrb, req_prot,
        input  req_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_write, req_addr,
        input  req_wdata, req_wstrb, req_prot,
        output req_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  rsp_ready
    );
endinterface

interface axi_lite_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one
// AXI read or write out, sticky bus-error and stall flags.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_lite_cmd_if.slave    cmd,
    axi_lite_if.master       axi,
    output logic             busy,
    input  logic             err_clr,
    output logic             resp_err,
    output logic             timeout_err
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT_CYCLES - 2);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [SW-1:0]         r_wstrb;
    logic [2:0]            r_prot;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic                  r_rsp_write;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]            r_rsp_resp;
    logic                  r_resp_err;
    logic                  r_timeout_err;
    logic [CW-1:0]         r_cnt;

    logic w_aw_done;
    logic w_w_done;
    logic w_in_phase;

    assign cmd.req_ready = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);

    assign axi.awaddr  = r_addr;
    assign axi.awprot  = r_prot;
    assign axi.awvalid = r_awvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wvalid  = r_wvalid;
    assign axi.bready  = r_bready;
    assign axi.araddr  = r_addr;
    assign axi.arprot  = r_prot;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;

    assign cmd.rsp_valid = r_rsp_valid;
    assign cmd.rsp_write = r_rsp_write;
    assign cmd.rsp_rdata = r_rsp_rdata;
    assign cmd.rsp_resp  = r_rsp_resp;

    assign resp_err    = r_resp_err;
    assign timeout_err = r_timeout_err;

    // A channel counts as done once its valid is gone or handshakes now.
    assign w_aw_done  = !r_awvalid || axi.awready;
    assign w_w_done   = !r_wvalid  || axi.wready;
    assign w_in_phase = (r_state == ST_WR_XFER) || (r_state == ST_WR_RESP)
                     || (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_prot        <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_resp_err    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            if (err_clr) begin
                r_resp_err    <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            // Flag lands together with the counter reaching its limit.
            if (w_in_phase && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CNT_PRE) r_timeout_err <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (cmd.req_valid) begin
                        r_addr  <= cmd.req_addr;
                        r_wdata <= cmd.req_wdata;
                        r_wstrb <= cmd.req_wstrb;
                        r_prot  <= cmd.req_prot;
                        r_cnt   <= '0;
                        if (cmd.req_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_XFER;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_XFER: begin
                    if (r_awvalid && axi.awready) r_awvalid <= 1'b0;
                    if (r_wvalid && axi.wready) r_wvalid <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (axi.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= axi.bresp;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        if (axi.bresp != RESP_OKAY) r_resp_err <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RD_ADDR: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (axi.rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= axi.rresp;
                        r_rsp_write <= 1'b0;
                        r_rsp_rdata <= axi.rdata;
                        r_rsp_valid <= 1'b1;
                        if (axi.rresp != RESP_OKAY) r_resp_err <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (cmd.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: negedge slave model with programmable
// delays, response scoreboard, timeout and reset scenarios.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct packed {
        logic          write;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err_clr = 1'b0;
    logic resp_err;
    logic timeout_err;

    always #5 clk = ~clk;

    axi_lite_cmd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cmd ();
    axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_lite_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd),
        .axi(axi),
        .busy(busy),
        .err_clr(err_clr),
        .resp_err(resp_err),
        .timeout_err(timeout_err)
    );

    int n_chk = 0;
    int n_pass = 0;
    rsp_t exp_q[$];

    int aw_dly = 0, w_dly = 0, b_dly = 0;
    int ar_dly = 0, r_dly = 0, rsp_hold = 0;
    logic [1:0] bresp_cfg = RESP_OKAY;
    logic [1:0] rresp_cfg = RESP_OKAY;
    logic [DW-1:0] rdata_cfg = '0;

    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
    int cyc = 0;
    int aw_hi = 0, w_hi = 0, ar_hi = 0, rsp_hi = 0, b_hs = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0;
    int aw_unstable = 0, rsp_unstable = 0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [3:0] cur_wstrb = '0;
    logic [2:0] cur_prot = '0;
    rsp_t rsp_first;
    rsp_t rsp_now;
    rsp_t rsp_exp;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clr_mon();
        aw_hi = 0; w_hi = 0; ar_hi = 0; rsp_hi = 0; b_hs = 0;
        aw_unstable = 0; rsp_unstable = 0;
        aw_hs_cyc = -1; w_hs_cyc = -2;
    endtask

    // Slave and response consumer, all driven on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!axi.awvalid) begin
            axi.awready = 1'b0; aw_cnt = 0;
        end else begin
            aw_hi++;
            if (axi.awaddr !== cur_addr) aw_unstable++;
            axi.awready = (aw_cnt >= aw_dly); aw_cnt++;
            if (axi.awready) begin
                aw_hs_cyc = cyc;
                chk("awaddr", axi.awaddr, cur_addr);
                chk("awprot", axi.awprot, cur_prot);
            end
        end
        if (!axi.wvalid) begin
            axi.wready = 1'b0; w_cnt = 0;
        end else begin
            w_hi++;
            axi.wready = (w_cnt >= w_dly); w_cnt++;
            if (axi.wready) begin
                w_hs_cyc = cyc;
                chk("wdata", axi.wdata, cur_wdata);
                chk("wstrb", axi.wstrb, cur_wstrb);
            end
        end
        axi.bresp = bresp_cfg;
        if (!axi.bready) begin
            axi.bvalid = 1'b0; b_cnt = 0;
        end else begin
            axi.bvalid = (b_cnt >= b_dly); b_cnt++;
            if (axi.bvalid) b_hs++;
        end
        if (!axi.arvalid) begin
            axi.arready = 1'b0; ar_cnt = 0;
        end else begin
            ar_hi++;
            axi.arready = (ar_cnt >= ar_dly); ar_cnt++;
            if (axi.arready) begin
                chk("araddr", axi.araddr, cur_addr);
                chk("arprot", axi.arprot, cur_prot);
            end
        end
        axi.rdata = rdata_cfg;
        axi.rresp = rresp_cfg;
        if (!axi.rready) begin
            axi.rvalid = 1'b0; r_cnt = 0;
        end else begin
            axi.rvalid = (r_cnt >= r_dly); r_cnt++;
        end
        if (!cmd.rsp_valid) begin
            cmd.rsp_ready = 1'b0; rsp_cnt = 0;
        end else begin
            rsp_now.write = cmd.rsp_write;
            rsp_now.rdata = cmd.rsp_rdata;
            rsp_now.resp  = cmd.rsp_resp;
            if (rsp_cnt == 0) rsp_first = rsp_now;
            else if (rsp_now !== rsp_first) rsp_unstable++;
            rsp_hi++;
            cmd.rsp_ready = (rsp_cnt >= rsp_hold); rsp_cnt++;
            if (cmd.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    rsp_exp = exp_q.pop_front();
                    chk("rsp_write", rsp_now.write, rsp_exp.write);
                    chk("rsp_rdata", rsp_now.rdata, rsp_exp.rdata);
                    chk("rsp_resp", rsp_now.resp, rsp_exp.resp);
                end
            end
        end
    end

    task automatic send(input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] s,
                        input logic [2:0] p, input rsp_t e);
        int n = 0;
        cur_addr = a; cur_wdata = d; cur_wstrb = s; cur_prot = p;
        cmd.req_valid = 1'b1;
        cmd.req_write = wr;
        cmd.req_addr  = a;
        cmd.req_wdata = d;
        cmd.req_wstrb = s;
        cmd.req_prot  = p;
        while (!cmd.req_ready && n < 100) begin
            @(negedge clk); n++;
        end
        chk("req_accept_bound", n < 100, 1);
        exp_q.push_back(e);
        @(negedge clk);
        cmd.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(negedge clk); n++;
        end
        chk("idle_bound", n < 500, 1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    function automatic rsp_t mk(input logic w, input logic [DW-1:0] d,
                                input logic [1:0] r);
        rsp_t t;
        t.write = w; t.rdata = d; t.resp = r;
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        cmd.req_valid = 1'b0; cmd.req_write = 1'b0;
        cmd.req_addr = '0; cmd.req_wdata = '0;
        cmd.req_wstrb = '0; cmd.req_prot = '0;
        cmd.rsp_ready = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0;
        axi.rdata = '0; axi.rresp = '0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", cmd.req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_rsp_valid", cmd.rsp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write, both channels ready at once
        clr_mon();
        send(1'b1, CSR_DMA_SRC, 32'hDEADBEEF, 4'hF, 3'b001,
             mk(1'b1, '0, RESP_OKAY));
        chk("wr_issue_aw", axi.awvalid, 1);
        chk("wr_issue_w", axi.wvalid, 1);
        wait_idle();
        chk("wr1_same_cycle", aw_hs_cyc, w_hs_cyc);
        chk("wr1_aw_hi", aw_hi, 1);
        chk("wr1_b_hs", b_hs, 1);
        chk("wr1_resp_err", resp_err, 0);

        // Write with awready delayed by 3
        clr_mon();
        aw_dly = 3;
        send(1'b1, CSR_DMA_LEN, 32'h0000_1234, 4'h3, 3'b010,
             mk(1'b1, '0, RESP_OKAY));
        wait_idle();
        chk("wr2_w_hi", w_hi, 1);
        chk("wr2_aw_hi", aw_hi, 4);
        chk("wr2_aw_stable", aw_unstable, 0);
        chk("wr2_b_hs", b_hs, 1);
        aw_dly = 0;

        // Read with arready delay 2, rvalid delay 1
        clr_mon();
        ar_dly = 2; r_dly = 1; rdata_cfg = 32'h0000_00A5;
        send(1'b0, CSR_DMA_CTRL, 32'hFFFF_FFFF, 4'h0, 3'b000,
             mk(1'b0, 32'h0000_00A5, RESP_OKAY));
        chk("rd_issue_ar", axi.arvalid, 1);
        wait_idle();
        chk("rd1_ar_hi", ar_hi, 3);
        chk("rd1_rsp_hi", rsp_hi, 1);
        chk("rd1_no_aw", aw_hi, 0);
        ar_dly = 0; r_dly = 0;

        // Read returning DECERR
        clr_mon();
        rresp_cfg = RESP_DECERR; rdata_cfg = 32'hCAFE_0001;
        send(1'b0, 8'h7F, '0, 4'h0, 3'b100,
             mk(1'b0, 32'hCAFE_0001, RESP_DECERR));
        wait_idle();
        chk("rd2_resp_err_set", resp_err, 1);
        repeat (3) @(negedge clk);
        chk("rd2_resp_err_sticky", resp_err, 1);
        pulse_clr();
        chk("rd2_resp_err_clr", resp_err, 0);
        rresp_cfg = RESP_OKAY;

        // Write with SLVERR response
        clr_mon();
        bresp_cfg = RESP_SLVERR;
        send(1'b1, CSR_DMA_DST, 32'h0BAD_F00D, 4'hC, 3'b000,
             mk(1'b1, '0, RESP_SLVERR));
        wait_idle();
        chk("wr3_resp_err", resp_err, 1);
        pulse_clr();
        chk("wr3_resp_err_clr", resp_err, 0);
        bresp_cfg = RESP_OKAY;

        // Timeout: bvalid withheld 40 cycles
        clr_mon();
        b_dly = 40;
        send(1'b1, CSR_DMA_STAT, 32'h5555_AAAA, 4'hF, 3'b000,
             mk(1'b1, '0, RESP_OKAY));
        chk("to_cycle1", timeout_err, 0);
        repeat (14) @(negedge clk);
        chk("to_cycle15", timeout_err, 0);
        @(negedge clk);
        chk("to_cycle16", timeout_err, 1);
        chk("to_bready_held", axi.bready, 1);
        chk("to_busy", busy, 1);
        wait_idle();
        chk("to_b_hs", b_hs, 1);
        chk("to_sticky", timeout_err, 1);
        chk("to_no_resp_err", resp_err, 0);
        pulse_clr();
        chk("to_clr", timeout_err, 0);
        b_dly = 0;

        // Response back-pressure with a pending request
        clr_mon();
        rsp_hold = 5; rdata_cfg = 32'h1234_5678;
        send(1'b0, CSR_DMA_DST, '0, 4'h0, 3'b000,
             mk(1'b0, 32'h1234_5678, RESP_OKAY));
        cmd.req_valid = 1'b1; cmd.req_write = 1'b1;
        cmd.req_addr = 8'h66; cmd.req_wdata = 32'h7777_7777;
        n = 0;
        while (!cmd.rsp_valid && n < 100) begin
            @(negedge clk); n++;
        end
        chk("bp_rsp_bound", n < 100, 1);
        chk("bp_req_ready_0", cmd.req_ready, 0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_req_ready", cmd.req_ready, 0);
        end
        cmd.req_valid = 1'b0;
        wait_idle();
        chk("bp_rsp_hi", rsp_hi, 6);
        chk("bp_rsp_stable", rsp_unstable, 0);
        chk("bp_no_stray_aw", aw_hi, 0);
        rsp_hold = 0;

        // Reset pulse in the middle of WR_XFER
        clr_mon();
        aw_dly = 10; w_dly = 10;
        send(1'b1, CSR_DMA_LEN, 32'h1111_2222, 4'hF, 3'b000,
             mk(1'b1, '0, RESP_OKAY));
        chk("rst_mid_pre", axi.awvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_awvalid", axi.awvalid, 0);
        chk("rst_mid_wvalid", axi.wvalid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_req_ready", cmd.req_ready, 1);
        chk("rst_mid_bready", axi.bready, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        aw_dly = 0; w_dly = 0;
        @(negedge clk);

        // Recovery write after reset
        clr_mon();
        send(1'b1, CSR_DMA_SRC, 32'h0000_0042, 4'h1, 3'b011,
             mk(1'b1, '0, RESP_OKAY));
        wait_idle();
        chk("post_rst_b_hs", b_hs, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
